fifo_byte_unpacker: RTL

Read-side consumer for the `fifo` block. It pops WIDTH-bit words from the FIFO and emits them one byte at a time on a valid/ready byte stream, for example to feed the UART transmitter. It supports both FIFO read modes, FWFT and standard registered-read with `dvld`, and keeps at most one FIFO read outstanding.

---
 rtl/fifo_byte_unpacker.sv | 114 +++++++++++
 1 files changed

// File: rtl/fifo_byte_unpacker.sv
// Pops WIDTH-bit words from a FIFO (FWFT or registered-read) and streams them out byte by byte.
// Build option: define FIFO_UNPACK_MSB_FIRST_EN to emit the most significant byte first.
module fifo_byte_unpacker #(
  parameter int WIDTH = 32,
  parameter bit FWFT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_dvld,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy
);

  localparam int NBYTES = WIDTH / 8;
  localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NBYTES - 1);

  if ((WIDTH % 8) != 0 || WIDTH < 8) begin : g_width_chk
    $error("fifo_byte_unpacker: WIDTH must be a non-zero multiple of 8");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  wbuf;
  logic [BIDX_W-1:0] bidx;
  logic              xfer;
  logic              last_byte;
  logic              pop_ok;
  logic [7:0]        byte_sel;

  assign m_valid   = (state == SHIFT);
  assign xfer      = m_valid && m_ready;
  assign last_byte = (bidx == LAST_IDX);

  // WAIT is excluded here, so a registered-read FIFO never sees a second pop while data is in flight.
  assign pop_ok  = rst && !fifo_empty &&
                   ((state == IDLE) || ((state == SHIFT) && last_byte && xfer));
  assign fifo_rd = pop_ok;

  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (bidx == BIDX_W'(i)) begin
`ifdef FIFO_UNPACK_MSB_FIRST_EN
        byte_sel = wbuf[WIDTH-1-8*i -: 8];
`else
        byte_sel = wbuf[8*i +: 8];
`endif
      end
    end
  end

  assign m_data = byte_sel;
  assign m_last = m_valid && last_byte;
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wbuf  <= '0;
      bidx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop_ok) begin
            if (FWFT) begin
              wbuf  <= fifo_dout;
              bidx  <= '0;
              state <= SHIFT;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (fifo_dvld) begin
            wbuf  <= fifo_dout;
            bidx  <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (!last_byte) begin
              bidx <= bidx + 1'b1;
            end else if (pop_ok) begin
              if (FWFT) begin
                wbuf <= fifo_dout;
                bidx <= '0;
              end else begin
                state <= WAIT;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
